rrf_free_list: RTL and testbench

Rename-register (RRF) free list for the two-wide superscalar core. It sits between decode and dispatch, alongside the rename map. It hands out up to two free physical tags per cycle to rename, and takes back up to two tags per cycle from ROB retirement. It also keeps a committed allocation pointer, so a `flush` can reclaim every tag allocated speculatively in one cycle.

---
 rtl/ss_pkg.sv | 18 +
 rtl/rrf_free_list.sv | 115 +++++++++++
 tb/tb_rrf_free_list.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// ============================================================================
// Module  : ss_pkg
// Brief   : Shared superscalar types: physical rename tag and RRF sizing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ss_pkg;

  localparam int SS_RRF_SIZE  = 7;
  localparam int SS_RRF_DEPTH = 1 << SS_RRF_SIZE;
  localparam int SS_ARCH_REGS = 8;

  typedef logic [SS_RRF_SIZE-1:0] rrf_tag_t;

endpackage

`default_nettype wire

// File: rtl/rrf_free_list.sv
// ============================================================================
// Module  : rrf_free_list
// Brief   : Two-wide rename-register free list with committed pointer for
//           single-cycle flush recovery. RRF_FREE_LIST_CHECK_EN enables err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rrf_free_list
  import ss_pkg::*;
#(
  parameter int RRF_SIZE  = SS_RRF_SIZE,
  parameter int ARCH_REGS = SS_ARCH_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [1:0]          alloc_cnt,
  output logic                alloc_ok,
  output logic [RRF_SIZE-1:0] alloc_tag0,
  output logic [RRF_SIZE-1:0] alloc_tag1,
  input  logic [1:0]          rel_cnt,
  input  logic [RRF_SIZE-1:0] rel_tag0,
  input  logic [RRF_SIZE-1:0] rel_tag1,
  input  logic [1:0]          commit_cnt,
  output logic [RRF_SIZE:0]   free_count,
  output logic                err
);

  localparam int DEPTH = 1 << RRF_SIZE;
  localparam int PW    = RRF_SIZE + 1;
  localparam int NFREE = DEPTH - ARCH_REGS;

  typedef logic [PW-1:0] ptr_t;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
    return p + ptr_t'(n);
  endfunction

  logic [RRF_SIZE-1:0] fl_q [DEPTH];
  ptr_t head_q, head_d;
  ptr_t chead_q, chead_d;
  ptr_t tail_q, tail_d;
  ptr_t head_p1, tail_p1;

  assign free_count = tail_q - head_q;
  assign head_p1    = ptr_add(head_q, 2'd1);
  assign tail_p1    = ptr_add(tail_q, 2'd1);
  assign alloc_tag0 = fl_q[head_q[RRF_SIZE-1:0]];
  assign alloc_tag1 = fl_q[head_p1[RRF_SIZE-1:0]];

  always_comb begin
    alloc_ok = reset && !stall && !flush && (alloc_cnt != 2'd0)
               && (free_count >= ptr_t'(alloc_cnt));
    chead_d  = ptr_add(chead_q, commit_cnt);
    tail_d   = ptr_add(tail_q, rel_cnt);
    head_d   = head_q;
    // Flush restores from the post-commit pointer so same-cycle commits stick.
    if (flush) begin
      head_d = chead_d;
    end else if (alloc_ok) begin
      head_d = ptr_add(head_q, alloc_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fl_q[i] <= RRF_SIZE'(ARCH_REGS + i);
      end
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= ptr_t'(NFREE);
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      if (rel_cnt != 2'd0) begin
        fl_q[tail_q[RRF_SIZE-1:0]] <= rel_tag0;
      end
      if (rel_cnt[1]) begin
        fl_q[tail_p1[RRF_SIZE-1:0]] <= rel_tag1;
      end
    end
  end

`ifdef RRF_FREE_LIST_CHECK_EN
  logic err_q, err_d;
  logic over_release, over_commit, bad_cnt;

  always_comb begin
    over_release = (rel_cnt != 2'd0) && ((tail_d - chead_d) > ptr_t'(NFREE));
    over_commit  = ptr_t'(commit_cnt) > (head_q - chead_q);
    bad_cnt      = (&alloc_cnt) || (&rel_cnt) || (&commit_cnt);
    err_d        = err_q || over_release || over_commit || bad_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rrf_free_list.sv
// ============================================================================
// Module  : tb_rrf_free_list
// Brief   : Scoreboard bench for rrf_free_list; stimulus pushes expectations,
//           a negedge monitor pops and compares. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rrf_free_list;
  import ss_pkg::*;

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic [1:0] alloc_cnt, rel_cnt, commit_cnt;
  rrf_tag_t   rel_tag0, rel_tag1, alloc_tag0, alloc_tag1;
  logic       alloc_ok, err;
  logic [7:0] free_count;

  rrf_free_list dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .alloc_cnt  (alloc_cnt),
    .alloc_ok   (alloc_ok),
    .alloc_tag0 (alloc_tag0),
    .alloc_tag1 (alloc_tag1),
    .rel_cnt    (rel_cnt),
    .rel_tag0   (rel_tag0),
    .rel_tag1   (rel_tag1),
    .commit_cnt (commit_cnt),
    .free_count (free_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] mask;   // {ok, tag0, tag1, free_count}
    logic       ok;
    rrf_tag_t   t0;
    rrf_tag_t   t1;
    logic [7:0] fc;
    logic       er;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_err = 1'b0;

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.mask[3]) cmp(e.name, "alloc_ok", int'(alloc_ok), int'(e.ok));
      if (e.mask[2]) cmp(e.name, "alloc_tag0", int'(alloc_tag0), int'(e.t0));
      if (e.mask[1]) cmp(e.name, "alloc_tag1", int'(alloc_tag1), int'(e.t1));
      if (e.mask[0]) cmp(e.name, "free_count", int'(free_count), int'(e.fc));
      cmp(e.name, "err", int'(err), int'(e.er));
    end
  end

  task automatic push(input string nm, input logic [3:0] m, input logic ok,
                      input int t0, input int t1, input int fc);
    exp_t e;
    e.name = nm; e.mask = m; e.ok = ok;
    e.t0 = rrf_tag_t'(t0); e.t1 = rrf_tag_t'(t1); e.fc = 8'(fc); e.er = exp_err;
    q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic st, input logic fl,
                       input logic [1:0] ac, input logic [1:0] rc,
                       input int r0, input int r1, input logic [1:0] cc);
    reset = rst; stall = st; flush = fl; alloc_cnt = ac;
    rel_cnt = rc; rel_tag0 = rrf_tag_t'(r0); rel_tag1 = rrf_tag_t'(r1); commit_cnt = cc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  rrf_tag_t mfl[$];
  rrf_tag_t prev0, prev1;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    tick(); tick();
    // Still in reset: request must not be granted.
    drive(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 0, 0, 2'd0);
    push("rst_hold", 4'b1111, 1'b0, 8, 9, 120);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    push("rst_idle", 4'b1111, 1'b0, 8, 9, 120);
    tick();

    // Two double allocations, then stall.
    drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 0, 0, 2'd0);
    push("alloc_a", 4'b1111, 1'b1, 8, 9, 120);
    tick();
    push("alloc_b", 4'b1111, 1'b1, 10, 11, 118);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 0, 0, 2'd0);
    push("stall_a", 4'b1111, 1'b0, 12, 13, 116);
    tick();
    push("stall_b", 4'b1111, 1'b0, 12, 13, 116);
    tick();

    // Commit one, then flush with a same-cycle commit: head returns to 2.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd1);
    push("commit1", 4'b1111, 1'b0, 12, 13, 116);
    tick();
    drive(1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 0, 0, 2'd1);
    push("flush", 4'b1111, 1'b0, 12, 13, 116);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    push("post_flush", 4'b1111, 1'b0, 10, 11, 118);
    tick();

    // Exhaustion: drain to one free tag, then all-or-nothing grant.
    drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 0, 0, 2'd0);
    for (int k = 0; k < 58; k++) begin
      push("drain", 4'b1111, 1'b1, 10 + 2 * k, 11 + 2 * k, 118 - 2 * k);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 0, 0, 2'd0);
    push("drain_one", 4'b1101, 1'b1, 126, 0, 2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 0, 0, 2'd0);
    push("short_a", 4'b1101, 1'b0, 127, 0, 1);
    tick();
    push("short_b", 4'b1101, 1'b0, 127, 0, 1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 0, 0, 2'd0);
    push("last_tag", 4'b1101, 1'b1, 127, 0, 1);
    tick();
    push("empty", 4'b1001, 1'b0, 0, 0, 0);
    tick();
    // Release into an empty list: no same-cycle bypass.
    drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 9, 0, 2'd0);
    push("rel_empty", 4'b1001, 1'b0, 0, 0, 0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 0, 0, 2'd0);
    push("rel_reuse", 4'b1101, 1'b1, 9, 0, 1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    push("empty2", 4'b1001, 1'b0, 0, 0, 0);
    tick();

    // Mid-operation reset ignores every other input.
    drive(1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 3, 4, 2'd2);
    push("mid_rst", 4'b1000, 1'b0, 0, 0, 0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    push("mid_rst_idle", 4'b1111, 1'b0, 8, 9, 120);
    tick();

    // Steady alloc/release/commit across several pointer wraps.
    for (int i = 8; i < 128; i++) mfl.push_back(rrf_tag_t'(i));
    drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 0, 0, 2'd0);
    push("wrap_warm", 4'b1111, 1'b1, 8, 9, 120);
    prev0 = mfl.pop_front();
    prev1 = mfl.pop_front();
    tick();
    for (int k = 1; k <= 200; k++) begin
      rrf_tag_t f0, f1;
      f0 = (k == 1) ? rrf_tag_t'(0) : prev0;
      f1 = (k == 1) ? rrf_tag_t'(1) : prev1;
      drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd2, int'(f0), int'(f1), 2'd2);
      push("wrap", 4'b1111, 1'b1, int'(mfl[0]), int'(mfl[1]), 118);
      prev0 = mfl.pop_front();
      prev1 = mfl.pop_front();
      mfl.push_back(f0);
      mfl.push_back(f1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, int'(prev0), int'(prev1), 2'd2);
    push("wrap_tail", 4'b1111, 1'b0, int'(mfl[0]), int'(mfl[1]), 118);
    mfl.push_back(prev0);
    mfl.push_back(prev1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    push("wrap_end", 4'b1111, 1'b0, int'(mfl[0]), int'(mfl[1]), 120);
    tick();

`ifdef RRF_FREE_LIST_CHECK_EN
    // Committed count already full: one more release is an error, sticky.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 5, 0, 2'd0);
    push("over_rel", 4'b1001, 1'b0, 0, 0, 120);
    tick();
    exp_err = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    push("err_set", 4'b0000, 1'b0, 0, 0, 0);
    tick();
    push("err_hold", 4'b0000, 1'b0, 0, 0, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    tick();
    exp_err = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0, 2'd0);
    push("err_clear", 4'b1111, 1'b0, 8, 9, 120);
    tick();
`endif

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: run still active at %0t, expected finish", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
